// File: rtl/game_ctl_pkg.sv
// Shared types and constants for the blobby volley match sequencer.
// Phase encodings are visible to the overlay logic through the state port.
package game_ctl_pkg;

    localparam int unsigned GAME_STATE_BITS = 3;
    localparam int unsigned SCORE_BITS      = 4;
    localparam int unsigned TIMER_BITS      = 7;

    typedef enum logic [GAME_STATE_BITS-1:0] {
        GAME_IDLE  = 3'd0,
        GAME_SERVE = 3'd1,
        GAME_RALLY = 3'd2,
        GAME_PAUSE = 3'd3,
        GAME_OVER  = 3'd4
    } game_state_e;

    // Registered match outputs, kept together so they update as one word
    typedef struct packed {
        logic                  ball_hold;
        logic                  ball_launch;
        logic                  serve_side;
        logic                  players_en;
        logic [SCORE_BITS-1:0] score_p1;
        logic [SCORE_BITS-1:0] score_p2;
        logic                  game_over;
        logic                  winner;
    } game_out_t;

    // Saturating increment so a score can never pass the winning score
    function automatic logic [SCORE_BITS-1:0] score_inc(
        input logic [SCORE_BITS-1:0] score,
        input logic [SCORE_BITS-1:0] limit
    );
        return (score >= limit) ? score : score + SCORE_BITS'(1);
    endfunction

endpackage

// File: rtl/game_ctl_edge_detect.sv
// Rising-edge detector: one-cycle pulse the cycle a level input goes high.
// The pulse is combinational so the sequencer acts on the edge it samples.
module game_ctl_edge_detect (
    input  logic pclk,
    input  logic rst,
    input  logic in,
    output logic rise_c
);

    logic r_in_d;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_in_d <= 1'b0;
        end else begin
            r_in_d <= in;
        end
    end

    assign rise_c = in & ~r_in_d;

endmodule

// File: rtl/game_ctl.sv
// Match sequencer: turns judge point pulses into idle/serve/rally/pause/over
// phases, drives ball hold/launch, player enable, serve side and scores.
module game_ctl
    import game_ctl_pkg::*;
#(
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned PAUSE_FRAMES = 90,
    parameter int unsigned WIN_SCORE    = 15
) (
    input  logic                       pclk,
    input  logic                       rst,
    input  logic                       vblnk,
    input  logic                       click,
    input  logic                       point_p1,
    input  logic                       point_p2,
    output logic                       ball_hold,
    output logic                       ball_launch,
    output logic                       serve_side,
    output logic                       players_en,
    output logic [SCORE_BITS-1:0]      score_p1,
    output logic [SCORE_BITS-1:0]      score_p2,
    output logic [GAME_STATE_BITS-1:0] state,
    output logic                       game_over,
    output logic                       winner
);

    localparam logic [TIMER_BITS-1:0] SERVE_LOAD = TIMER_BITS'(SERVE_FRAMES);
    localparam logic [TIMER_BITS-1:0] PAUSE_LOAD = TIMER_BITS'(PAUSE_FRAMES);
    localparam logic [SCORE_BITS-1:0] WIN_VAL    = SCORE_BITS'(WIN_SCORE);

    logic w_tick;
    logic w_click_edge;

    game_state_e           r_state;
    game_state_e           w_state_nxt;
    logic [TIMER_BITS-1:0] r_timer;
    logic [TIMER_BITS-1:0] w_timer_nxt;
    game_out_t             r_out;
    game_out_t             w_out_nxt;
    logic [SCORE_BITS-1:0] w_score;

    game_ctl_edge_detect u_vblnk_edge (
        .pclk   (pclk),
        .rst    (rst),
        .in     (vblnk),
        .rise_c (w_tick)
    );

    game_ctl_edge_detect u_click_edge (
        .pclk   (pclk),
        .rst    (rst),
        .in     (click),
        .rise_c (w_click_edge)
    );

    // State, frame timer and output word registers
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_state         <= GAME_IDLE;
            r_timer         <= '0;
            r_out           <= '0;
            r_out.ball_hold <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // Next phase, timer and output word
    always_comb begin
        w_state_nxt           = r_state;
        w_timer_nxt           = r_timer;
        w_out_nxt             = r_out;
        w_out_nxt.ball_launch = 1'b0;
        w_score               = '0;

        case (r_state)
            GAME_IDLE: begin
                w_out_nxt.score_p1 = '0;
                w_out_nxt.score_p2 = '0;
                if (w_click_edge) begin
                    w_state_nxt          = GAME_SERVE;
                    w_out_nxt.serve_side = 1'b0;
                    w_timer_nxt          = SERVE_LOAD;
                end
            end

            GAME_SERVE: begin
                if (w_tick) begin
                    if (r_timer == '0) begin
                        w_state_nxt           = GAME_RALLY;
                        w_out_nxt.ball_launch = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer - TIMER_BITS'(1);
                    end
                end
            end

            GAME_RALLY: begin
                // Player 1 wins a tie; the simultaneous player 2 pulse is dropped
                if (point_p1 || point_p2) begin
                    if (point_p1) begin
                        w_score              = score_inc(r_out.score_p1, WIN_VAL);
                        w_out_nxt.score_p1   = w_score;
                        w_out_nxt.serve_side = 1'b0;
                    end else begin
                        w_score              = score_inc(r_out.score_p2, WIN_VAL);
                        w_out_nxt.score_p2   = w_score;
                        w_out_nxt.serve_side = 1'b1;
                    end
                    if (w_score == WIN_VAL) begin
                        w_state_nxt      = GAME_OVER;
                        w_out_nxt.winner = ~point_p1;
                    end else begin
                        w_state_nxt = GAME_PAUSE;
                        w_timer_nxt = PAUSE_LOAD;
                    end
                end
            end

            GAME_PAUSE: begin
                if (w_tick) begin
                    if (r_timer == '0) begin
                        w_state_nxt = GAME_SERVE;
                        w_timer_nxt = SERVE_LOAD;
                    end else begin
                        w_timer_nxt = r_timer - TIMER_BITS'(1);
                    end
                end
            end

            GAME_OVER: begin
                if (w_click_edge) begin
                    w_state_nxt          = GAME_IDLE;
                    w_out_nxt.score_p1   = '0;
                    w_out_nxt.score_p2   = '0;
                    w_out_nxt.serve_side = 1'b0;
                end
            end

            default: begin
                w_state_nxt          = GAME_IDLE;
                w_timer_nxt          = '0;
                w_out_nxt.score_p1   = '0;
                w_out_nxt.score_p2   = '0;
                w_out_nxt.serve_side = 1'b0;
            end
        endcase

        // Phase-level flags follow the phase being entered
        w_out_nxt.ball_hold  = (w_state_nxt != GAME_RALLY);
        w_out_nxt.players_en = (w_state_nxt == GAME_SERVE) || (w_state_nxt == GAME_RALLY);
        w_out_nxt.game_over  = (w_state_nxt == GAME_OVER);
    end

    assign state       = r_state;
    assign ball_hold   = r_out.ball_hold;
    assign ball_launch = r_out.ball_launch;
    assign serve_side  = r_out.serve_side;
    assign players_en  = r_out.players_en;
    assign score_p1    = r_out.score_p1;
    assign score_p2    = r_out.score_p2;
    assign game_over   = r_out.game_over;
    assign winner      = r_out.winner;

endmodule

// File: tb/tb_game_ctl.sv
// Bench for game_ctl: directed match scenarios then randomized play, every
// cycle compared against a duration-based behavioural model of the match.
module tb_game_ctl;

    localparam int unsigned SERVE_FRAMES = 2;
    localparam int unsigned PAUSE_FRAMES = 3;
    localparam int unsigned WIN_SCORE    = 3;
    localparam logic [16:0] RST_WORD     = 17'h02000;

    logic       pclk = 1'b0;
    logic       rst;
    logic       vblnk;
    logic       click;
    logic       point_p1;
    logic       point_p2;
    logic       ball_hold;
    logic       ball_launch;
    logic       serve_side;
    logic       players_en;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [2:0] state;
    logic       game_over;
    logic       winner;

    int n_tests = 0;
    int n_fail  = 0;
    int n_launch = 0;

    // model: phase 0 idle, 1 serve, 2 rally, 3 pause, 4 over
    int m_phase, m_left, m_s1, m_s2;
    bit m_side, m_win, m_launch, m_pv, m_pc;

    game_ctl #(
        .SERVE_FRAMES (SERVE_FRAMES),
        .PAUSE_FRAMES (PAUSE_FRAMES),
        .WIN_SCORE    (WIN_SCORE)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .vblnk       (vblnk),
        .click       (click),
        .point_p1    (point_p1),
        .point_p2    (point_p2),
        .ball_hold   (ball_hold),
        .ball_launch (ball_launch),
        .serve_side  (serve_side),
        .players_en  (players_en),
        .score_p1    (score_p1),
        .score_p2    (score_p2),
        .state       (state),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 pclk = ~pclk;

    function automatic logic [16:0] obs_word();
        return {state, ball_hold, ball_launch, serve_side, players_en,
                score_p1, score_p2, game_over, winner};
    endfunction

    function automatic logic [16:0] exp_word();
        logic hold, en, over;
        hold = (m_phase != 2);
        en   = (m_phase == 1) || (m_phase == 2);
        over = (m_phase == 4);
        return {3'(m_phase), hold, m_launch, m_side, en,
                4'(m_s1), 4'(m_s2), over, m_win};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_s1 = 0; m_s2 = 0;
        m_side = 0; m_win = 0; m_launch = 0; m_pv = 0; m_pc = 0;
    endtask

    // Match rules stated as tick budgets: N frames means N+1 ticks in phase
    task automatic model_step(input bit v, input bit c, input bit p1, input bit p2);
        bit tick, ce;
        tick = v && !m_pv;
        ce   = c && !m_pc;
        m_pv = v;
        m_pc = c;
        m_launch = 0;
        case (m_phase)
            0: if (ce) begin m_phase = 1; m_side = 0; m_left = SERVE_FRAMES + 1; end
            1: if (tick) begin
                   m_left--;
                   if (m_left == 0) begin m_phase = 2; m_launch = 1; end
               end
            2: if (p1 || p2) begin
                   if (p1) begin m_s1++; m_side = 0; end
                   else    begin m_s2++; m_side = 1; end
                   if ((p1 ? m_s1 : m_s2) == WIN_SCORE) begin
                       m_phase = 4; m_win = !p1;
                   end else begin
                       m_phase = 3; m_left = PAUSE_FRAMES + 1;
                   end
               end
            3: if (tick) begin
                   m_left--;
                   if (m_left == 0) begin m_phase = 1; m_left = SERVE_FRAMES + 1; end
               end
            default: if (ce) begin m_phase = 0; m_s1 = 0; m_s2 = 0; m_side = 0; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it
    task automatic cyc(input bit v, input bit c, input bit p1, input bit p2);
        vblnk = v; click = c; point_p1 = p1; point_p2 = p2;
        @(posedge pclk);
        if (rst) model_step(v, c, p1, p2);
        else     model_reset();
        #1;
        if (ball_launch === 1'b1) n_launch++;
        chk("model", 32'(obs_word()), 32'(exp_word()));
    endtask

    task automatic frames(input int n, input bit c);
        for (int k = 0; k < n; k++) begin
            cyc(1, c, 0, 0);
            cyc(0, c, 0, 0);
        end
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        chk("async_rst", 32'(obs_word()), 32'(RST_WORD));
    endtask

    initial begin
        bit c_lvl;
        rst = 1'b0; vblnk = 0; click = 0; point_p1 = 0; point_p2 = 0;
        model_reset();
        repeat (3) cyc(0, 0, 0, 0);
        chk("reset_word", 32'(obs_word()), 32'(RST_WORD));
        rst = 1'b1;
        cyc(0, 0, 0, 0);

        // serve sequence with click held high throughout
        cyc(0, 1, 0, 0);
        chk("idle_to_serve", 32'(state), 32'd1);
        chk("serve_en", 32'(players_en), 32'd1);
        n_launch = 0;
        frames(2, 1);
        chk("serve_hold_after_2", 32'(state), 32'd1);
        cyc(1, 1, 0, 0);
        chk("launch_state", 32'(state), 32'd2);
        chk("launch_pulse", 32'(ball_launch), 32'd1);
        cyc(0, 0, 0, 0);
        chk("launch_once", 32'(n_launch), 32'd1);
        chk("rally_hold", 32'(ball_hold), 32'd0);

        // player 2 point then pause
        cyc(0, 0, 0, 1);
        chk("p2_score", 32'(score_p2), 32'd1);
        chk("p2_side", 32'(serve_side), 32'd1);
        chk("p2_pause", 32'(state), 32'd3);
        frames(3, 0);
        chk("pause_still", 32'(state), 32'd3);
        frames(1, 0);
        chk("pause_to_serve", 32'(state), 32'd1);
        frames(3, 0);

        // simultaneous points, then points ignored in pause
        cyc(0, 0, 1, 1);
        chk("tie_p1", 32'(score_p1), 32'd1);
        chk("tie_p2", 32'(score_p2), 32'd1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        chk("pause_ignore", 32'({score_p1, score_p2}), 32'h11);

        // player 1 wins the match
        frames(4, 0); frames(3, 0);
        cyc(0, 0, 1, 0);
        frames(4, 0); frames(3, 0);
        cyc(0, 0, 1, 0);
        chk("win_state", 32'(state), 32'd4);
        chk("win_flag", 32'(game_over), 32'd1);
        chk("win_who", 32'(winner), 32'd0);
        chk("win_score", 32'(score_p1), 32'd3);
        frames(2, 0);
        cyc(0, 1, 0, 0);
        chk("over_to_idle", 32'(state), 32'd0);
        chk("idle_clear", 32'({score_p1, score_p2}), 32'h0);

        // reset in the middle of a rally
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        frames(3, 0);
        chk("pre_rst_rally", 32'(state), 32'd2);
        async_reset();
        n_launch = 0;
        frames(2, 0);
        chk("rst_no_launch", 32'(n_launch), 32'd0);
        rst = 1'b1;

        // randomized play
        c_lvl = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                async_reset();
                repeat (3) cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1, 1);
                rst = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) c_lvl = ~c_lvl;
            cyc($urandom_range(0, 4) == 0, c_lvl,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
